// File: rtl/rsa_pkg.sv
// rsa_pkg: shared definitions for the RSA command dispatcher.
//   - command opcodes carried in arm_to_fpga_cmd[3:0]
//   - command word field positions (opcode, core index, broadcast flag)
//   - dispatcher state encoding (also exported on the leds)
//   - helper that classifies operand-load opcodes
package rsa_pkg;

  // Command opcodes
  localparam logic [3:0] CMD_READ_A       = 4'h0;
  localparam logic [3:0] CMD_READ_B       = 4'h1;
  localparam logic [3:0] CMD_READ_M       = 4'h2;
  localparam logic [3:0] CMD_COMPUTE_EXP  = 4'h3;
  localparam logic [3:0] CMD_COMPUTE_MONT = 4'h4;
  localparam logic [3:0] CMD_READ_E       = 4'h5;
  localparam logic [3:0] CMD_READ_R2      = 4'h6;
  localparam logic [3:0] CMD_READ_X       = 4'h7;
  localparam logic [3:0] CMD_READ_N       = 4'h8;
  localparam logic [3:0] CMD_READ_NP      = 4'h9;
  localparam logic [3:0] CMD_WRITE        = 4'ha;
  localparam logic [3:0] CMD_RESET_MONT   = 4'hb;

  // Command word field positions
  localparam int CMD_OP_LSB    = 0;
  localparam int CMD_IDX_LSB   = 8;
  localparam int CMD_BCAST_BIT = 31;

  // Dispatcher states; the encoding is visible on leds[3:1]
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX    = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_TX    = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // True for opcodes that move an operand from the ARM into the cores
  function automatic logic is_operand_op(input logic [3:0] op);
    return (op <= CMD_READ_M) || ((op >= CMD_READ_E) && (op <= CMD_READ_NP));
  endfunction

endpackage

// File: rtl/rsa_done_tracker.sv
// rsa_done_tracker: tracks which started cores have not yet reported done
// and counts compute cycles for the optional timeout.
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   start          load pending := mask and clear the cycle counter
//   active         dispatcher is waiting for completions this cycle
//   mask           cores started by the current command
//   core_done      per-core completion pulses
//   all_done       no core remains pending after this cycle's pulses
//   timeout        counter expired while cores are still pending
module rsa_done_tracker
  import rsa_pkg::*;
#(
  parameter int          NUM_CORES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 active,
  input  logic [NUM_CORES-1:0] mask,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 all_done,
  output logic                 timeout
);

  logic [NUM_CORES-1:0] pending_r;
  logic [NUM_CORES-1:0] pending_next_s;
  logic [31:0]          cnt_r;
  logic                 expire_s;

  // Done pulses on non-pending cores fall out of the AND; a pulse in the
  // expiry cycle still counts, so the timeout only fires if bits remain.
  always_comb begin
    pending_next_s = pending_r & ~core_done;
    expire_s       = 1'b0;
    if (TIMEOUT_CYCLES != 32'd0) begin
      expire_s = (cnt_r == 32'(TIMEOUT_CYCLES - 32'd1));
    end else begin
      expire_s = 1'b0;
    end
    all_done = active && (pending_next_s == '0);
    timeout  = active && expire_s && (pending_next_s != '0);
  end

  // Pending mask and compute-cycle counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_r <= '0;
      cnt_r     <= 32'd0;
    end else if (start) begin
      pending_r <= mask;
      cnt_r     <= 32'd0;
    end else if (active) begin
      pending_r <= timeout ? '0 : pending_next_s;
      cnt_r     <= cnt_r + 32'd1;
    end
  end

endmodule

// File: rtl/rsa_cmd_dispatcher.sv
// rsa_cmd_dispatcher: ARM-side command front end for an array of RSA cores.
// Accepts a command word, then loads an operand, starts a compute, returns a
// core result or soft-resets cores, and signals completion with done/done_read.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   arm_to_fpga_cmd[_valid]          command word and strobe
//   fpga_to_arm_done[_read]          completion flag and its acknowledge
//   arm_to_fpga_data*                operand input handshake
//   fpga_to_arm_data*                result output handshake
//   core_ld_en/sel/data              operand load strobes, opcode and bus
//   core_start/mode                  compute start strobes and mode
//   core_soft_rst                    soft reset strobes
//   core_done/result                 per-core completion pulses and results
//   status_err                       sticky error flag
//   leds                             {state, status_err}
module rsa_cmd_dispatcher
  import rsa_pkg::*;
#(
  parameter int          DATA_W         = 1024,
  parameter int          NUM_CORES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [31:0]                   arm_to_fpga_cmd,
  input  logic                          arm_to_fpga_cmd_valid,
  output logic                          fpga_to_arm_done,
  input  logic                          fpga_to_arm_done_read,
  input  logic                          arm_to_fpga_data_valid,
  output logic                          arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0]             arm_to_fpga_data,
  output logic                          fpga_to_arm_data_valid,
  input  logic                          fpga_to_arm_data_ready,
  output logic [DATA_W-1:0]             fpga_to_arm_data,
  output logic [NUM_CORES-1:0]          core_ld_en,
  output logic [3:0]                    core_ld_sel,
  output logic [DATA_W-1:0]             core_ld_data,
  output logic [NUM_CORES-1:0]          core_start,
  output logic                          core_mode,
  output logic [NUM_CORES-1:0]          core_soft_rst,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES*DATA_W-1:0]   core_result,
  output logic                          status_err,
  output logic [3:0]                    leds
);

  state_t               state_r;
  logic [7:0]           cmd_idx_r;
  logic [NUM_CORES-1:0] mask_r;
  logic                 rx_got_r;

  logic [3:0]           op_s;
  logic [7:0]           idx_s;
  logic                 bcast_s;
  logic [NUM_CORES-1:0] mask_s;
  logic                 illegal_s;
  logic [DATA_W-1:0]    result_sel_s;
  logic                 all_done_s;
  logic                 timeout_s;
  logic                 unused_cmd_s;

  assign op_s         = arm_to_fpga_cmd[CMD_OP_LSB +: 4];
  assign idx_s        = arm_to_fpga_cmd[CMD_IDX_LSB +: 8];
  assign bcast_s      = arm_to_fpga_cmd[CMD_BCAST_BIT];
  assign unused_cmd_s = ^{arm_to_fpga_cmd[30:16], arm_to_fpga_cmd[7:4]};
  assign leds         = {state_r, status_err};

  // Decode target mask and legality of the incoming command
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      mask_s[i] = bcast_s || (idx_s == 8'(i));
    end
    illegal_s = (op_s > CMD_RESET_MONT)
             || (!bcast_s && (idx_s >= 8'(NUM_CORES)))
             || ((op_s == CMD_WRITE) && bcast_s);
  end

  // Result slice of the addressed core (index is known legal in TX)
  always_comb begin
    result_sel_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      result_sel_s = (cmd_idx_r == 8'(i)) ? core_result[i*DATA_W +: DATA_W] : result_sel_s;
    end
  end

  rsa_done_tracker #(
    .NUM_CORES      (NUM_CORES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_done_tracker (
    .clk       (clk),
    .resetn    (resetn),
    .start     (state_r == ST_START),
    .active    (state_r == ST_WAIT),
    .mask      (mask_r),
    .core_done (core_done),
    .all_done  (all_done_s),
    .timeout   (timeout_s)
  );

  // Dispatcher FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r                <= ST_IDLE;
      cmd_idx_r              <= 8'd0;
      mask_r                 <= '0;
      rx_got_r               <= 1'b0;
      fpga_to_arm_done       <= 1'b0;
      arm_to_fpga_data_ready <= 1'b0;
      fpga_to_arm_data_valid <= 1'b0;
      fpga_to_arm_data       <= '0;
      core_ld_en             <= '0;
      core_ld_sel            <= 4'd0;
      core_ld_data           <= '0;
      core_start             <= '0;
      core_mode              <= 1'b0;
      core_soft_rst          <= '0;
      status_err             <= 1'b0;
    end else begin
      core_ld_en    <= '0;
      core_start    <= '0;
      core_soft_rst <= '0;
      if (arm_to_fpga_cmd_valid && (state_r != ST_IDLE)) begin
        status_err <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (arm_to_fpga_cmd_valid) begin
            cmd_idx_r <= idx_s;
            mask_r    <= mask_s;
            if (illegal_s) begin
              status_err       <= 1'b1;
              fpga_to_arm_done <= 1'b1;
              state_r          <= ST_DONE;
            end else if (is_operand_op(op_s)) begin
              core_ld_sel            <= op_s;
              arm_to_fpga_data_ready <= 1'b1;
              rx_got_r               <= 1'b0;
              state_r                <= ST_RX;
            end else if ((op_s == CMD_COMPUTE_EXP) || (op_s == CMD_COMPUTE_MONT)) begin
              // Start is issued on entry so it appears one cycle after the command
              core_start <= mask_s;
              core_mode  <= (op_s == CMD_COMPUTE_EXP);
              state_r    <= ST_START;
            end else if (op_s == CMD_WRITE) begin
              state_r <= ST_TX;
            end else begin
              // Only the legal soft-reset opcode remains here
              core_soft_rst    <= mask_s;
              fpga_to_arm_done <= 1'b1;
              state_r          <= ST_DONE;
            end
          end
        end
        ST_RX: begin
          // Capture on the handshake, spend one cycle with ready low, then load
          if (rx_got_r) begin
            rx_got_r   <= 1'b0;
            core_ld_en <= mask_r;
            state_r    <= ST_LOAD;
          end else if (arm_to_fpga_data_valid && arm_to_fpga_data_ready) begin
            core_ld_data           <= arm_to_fpga_data;
            arm_to_fpga_data_ready <= 1'b0;
            rx_got_r               <= 1'b1;
          end
        end
        ST_LOAD: begin
          fpga_to_arm_done <= 1'b1;
          state_r          <= ST_DONE;
        end
        ST_START: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (all_done_s) begin
            fpga_to_arm_done <= 1'b1;
            state_r          <= ST_DONE;
          end else if (timeout_s) begin
            status_err       <= 1'b1;
            fpga_to_arm_done <= 1'b1;
            state_r          <= ST_DONE;
          end
        end
        ST_TX: begin
          // First TX cycle registers the result; valid then holds until taken
          if (!fpga_to_arm_data_valid) begin
            fpga_to_arm_data       <= result_sel_s;
            fpga_to_arm_data_valid <= 1'b1;
          end else if (fpga_to_arm_data_ready) begin
            fpga_to_arm_data_valid <= 1'b0;
            fpga_to_arm_done       <= 1'b1;
            state_r                <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (fpga_to_arm_done_read) begin
            fpga_to_arm_done <= 1'b0;
            state_r          <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_cmd_dispatcher.sv
// tb_rsa_cmd_dispatcher: directed self-checking bench for rsa_cmd_dispatcher
// (DATA_W=1024, NUM_CORES=2, TIMEOUT_CYCLES=20). Inputs change 1 time unit
// after a rising edge; outputs are checked at the same point.
module tb_rsa_cmd_dispatcher;

  localparam int DW = 1024;
  localparam int NC = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic [31:0]    cmd;
  logic           cmd_valid;
  logic           done;
  logic           done_read;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [NC-1:0]  ld_en;
  logic [3:0]     ld_sel;
  logic [DW-1:0]  ld_data;
  logic [NC-1:0]  start;
  logic           mode;
  logic [NC-1:0]  soft_rst;
  logic [NC-1:0]  cdone;
  logic [NC*DW-1:0] cresult;
  logic           err;
  logic [3:0]     leds;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] a5_pattern;

  always #5 clk = ~clk;

  rsa_cmd_dispatcher #(.DATA_W(DW), .NUM_CORES(NC), .TIMEOUT_CYCLES(20)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .arm_to_fpga_cmd        (cmd),
    .arm_to_fpga_cmd_valid  (cmd_valid),
    .fpga_to_arm_done       (done),
    .fpga_to_arm_done_read  (done_read),
    .arm_to_fpga_data_valid (in_valid),
    .arm_to_fpga_data_ready (in_ready),
    .arm_to_fpga_data       (in_data),
    .fpga_to_arm_data_valid (out_valid),
    .fpga_to_arm_data_ready (out_ready),
    .fpga_to_arm_data       (out_data),
    .core_ld_en             (ld_en),
    .core_ld_sel            (ld_sel),
    .core_ld_data           (ld_data),
    .core_start             (start),
    .core_mode              (mode),
    .core_soft_rst          (soft_rst),
    .core_done              (cdone),
    .core_result            (cresult),
    .status_err             (err),
    .leds                   (leds)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ack_done();
    done_read = 1'b1;
    step();
    done_read = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cmd = 32'd0; cmd_valid = 1'b0; done_read = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cdone = '0; cresult = '0;
    a5_pattern = {128{8'hA5}};
    step(); step();

    // Reset state
    check("rst_done", done, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_strobes", {ld_en, start, soft_rst}, 6'd0);
    check("rst_leds", leds, 4'h0);
    resetn = 1'b1;
    step();

    // READ_A to core 1
    cmd = 32'h0000_0100; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("rx_ready", in_ready, 1'b1);
    check("rx_leds", leds, 4'h2);
    step(); step();
    check("rx_ready_held", in_ready, 1'b1);
    in_data = a5_pattern; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rx_ready_drop", in_ready, 1'b0);
    check("rx_no_ld_yet", ld_en, 2'b00);
    step();
    check("ld_en", ld_en, 2'b10);
    check("ld_sel", ld_sel, 4'h0);
    check("ld_data", ld_data, a5_pattern);
    check("ld_done_low", done, 1'b0);
    step();
    check("ld_en_one_cycle", ld_en, 2'b00);
    check("ld_done", done, 1'b1);
    step(); step();
    check("ld_done_held", done, 1'b1);
    ack_done();
    check("ld_done_drop", done, 1'b0);
    check("ld_err", err, 1'b0);

    // Broadcast COMPUTE_MONT, core 0 finishes first, core 1 later
    cmd = 32'h8000_0004; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("bc_start", start, 2'b11);
    check("bc_mode", mode, 1'b0);
    step();
    check("bc_start_one_cycle", start, 2'b00);
    step(); step(); step();
    cdone = 2'b01;
    step();
    cdone = 2'b00;
    check("bc_after_first", done, 1'b0);
    step(); step(); step();
    check("bc_still_waiting", done, 1'b0);
    cdone = 2'b10;
    step();
    cdone = 2'b00;
    check("bc_done", done, 1'b1);
    check("bc_err", err, 1'b0);
    ack_done();

    // WRITE from core 1 with the ARM stalling three cycles
    cresult = {1024'h1234, 1024'hDEAD};
    cmd = 32'h0000_010a; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("tx_entry_valid", out_valid, 1'b0);
    step();
    check("tx_valid", out_valid, 1'b1);
    check("tx_data", out_data, 1024'h1234);
    step(); step(); step();
    check("tx_valid_held", out_valid, 1'b1);
    check("tx_no_done", done, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("tx_valid_drop", out_valid, 1'b0);
    check("tx_done", done, 1'b1);
    check("tx_data_hold", out_data, 1024'h1234);
    ack_done();

    // Soft reset of core 0
    cmd = 32'h0000_000b; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("srst_pulse", soft_rst, 2'b01);
    check("srst_done", done, 1'b1);
    step();
    check("srst_one_cycle", soft_rst, 2'b00);
    ack_done();
    check("srst_err", err, 1'b0);

    // COMPUTE_EXP on core 0 that never completes: timeout after 20 WAIT cycles
    cmd = 32'h0000_0003; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("to_start", start, 2'b01);
    check("to_mode", mode, 1'b1);
    repeat (20) step();
    check("to_not_yet", done, 1'b0);
    step();
    check("to_done", done, 1'b1);
    check("to_err", err, 1'b1);
    check("to_leds", leds, 4'hD);
    ack_done();

    // Reset, then illegal core index
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("rst2_err", err, 1'b0);
    cmd = 32'h0000_0500; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("ill_done", done, 1'b1);
    check("ill_err", err, 1'b1);
    check("ill_strobes", {ld_en, start, soft_rst}, 6'd0);
    check("ill_ready", in_ready, 1'b0);
    ack_done();

    // Reset, then a command strobe while waiting on a compute
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    cmd = 32'h0000_0004; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    cmd = 32'h0000_000b; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("wait_cmd_err", err, 1'b1);
    check("wait_cmd_ignored", soft_rst, 2'b00);
    check("wait_cmd_leds", leds, 4'h9);
    cdone = 2'b01;
    step();
    cdone = 2'b00;
    check("wait_cmd_done", done, 1'b1);
    ack_done();

    // Reset in the middle of a WRITE
    cmd = 32'h0000_010a; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    check("txr_valid", out_valid, 1'b1);
    resetn = 1'b0;
    step();
    check("txr_valid_clr", out_valid, 1'b0);
    check("txr_data_clr", out_data, '0);
    check("txr_leds", leds, 4'h0);
    check("txr_done", done, 1'b0);
    resetn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_cmd_dispatcher.md
Name: rsa_cmd_dispatcher

Overview:
- Parametrised ARM-to-accelerator front end. Implements the cmd / data-in / data-out / done handshake protocol towards the ARM side and dispatches operand loads, compute starts and soft resets to NUM_CORES Montgomery/exponentiation cores.
- Successor to the single-core wrapper. Adds per-command core addressing, broadcast, a compute timeout and sticky error status.
- Sits between the ARM interface and the core array in the top-level rsa wrapper.

Parameters:
- DATA_W, 1024, operand and result width in bits.
- NUM_CORES, 2, number of attached cores, 1..255.
- TIMEOUT_CYCLES, 0, maximum compute cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- arm_to_fpga_cmd  in  32  command word: [3:0] opcode, [15:8] core index, [31] broadcast
- arm_to_fpga_cmd_valid  in  1  command strobe
- fpga_to_arm_done  out  1  command complete
- fpga_to_arm_done_read  in  1  ARM acknowledges done
- arm_to_fpga_data_valid  in  1  input data valid
- arm_to_fpga_data_ready  out  1  dispatcher ready to accept input data
- arm_to_fpga_data  in  DATA_W  input operand
- fpga_to_arm_data_valid  out  1  output data valid
- fpga_to_arm_data_ready  in  1  ARM ready to accept output data
- fpga_to_arm_data  out  DATA_W  result to ARM
- core_ld_en  out  NUM_CORES  one-cycle operand load strobe per core
- core_ld_sel  out  4  opcode of the operand being loaded (0x0-0x2, 0x5-0x9)
- core_ld_data  out  DATA_W  operand bus shared by all cores
- core_start  out  NUM_CORES  one-cycle start strobe per core
- core_mode  out  1  0 = Montgomery multiply, 1 = exponentiation; valid while core_start is high
- core_soft_rst  out  NUM_CORES  one-cycle soft reset strobe per core
- core_done  in  NUM_CORES  one-cycle completion pulse per core
- core_result  in  NUM_CORES*DATA_W  packed core results; core i occupies [i*DATA_W +: DATA_W]
- status_err  out  1  sticky error flag
- leds  out  4  {state[2:0], status_err}

Behaviour:
- Reset (resetn low at a clock edge): all outputs 0, state IDLE, pending mask 0, timeout counter 0, error cleared. Reset mid-operation aborts immediately. No strobe is issued in the reset cycle.

States: IDLE, RX, LOAD, START, WAIT, TX, DONE.
- IDLE: cmd_valid samples cmd into a register. Target mask = all cores if bit 31 is set, otherwise one-hot of the index. Transition by opcode:
  - Operand opcodes 0x0-0x2 and 0x5-0x9 -> RX.
  - 0x3 / 0x4 -> START.
  - 0xa -> TX.
  - 0xb -> DONE, pulsing core_soft_rst[mask] in the transition cycle.
- Illegal commands, each of which sets status_err, issues no strobes and goes -> DONE:
  - undefined opcode;
  - index >= NUM_CORES without broadcast;
  - WRITE with broadcast.
- RX: data_ready = 1. On valid & ready, capture data into core_ld_data; next cycle ready = 0 -> LOAD. Ready stays high indefinitely until valid arrives.
- LOAD: core_ld_en = mask for exactly one cycle -> DONE.
- START: core_start = mask for one cycle; core_mode = 1 for 0x3, 0 for 0x4. Pending mask := mask; timeout counter := 0 -> WAIT.
- WAIT:
  - Each core_done[i] clears pending[i]. Pulses on non-pending cores are ignored.
  - Pending mask == 0 -> DONE.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES -> set status_err, clear pending, -> DONE.
  - A done pulse arriving in the same cycle as expiry counts; the timeout wins only if bits remain pending.
- TX: in the entry cycle register the selected core_result slice into fpga_to_arm_data. data_valid = 1 from the next cycle until valid & ready, then -> DONE. Output data holds its value after transfer.
- DONE: fpga_to_arm_done = 1, held until done_read is sampled high -> IDLE. done drops in the cycle after done_read.
- cmd_valid outside IDLE: ignored, sets status_err.
- status_err clears only on reset.
- Minimum latencies:
  - Load command: cmd_valid to done = 3 cycles after the data transfer.
  - Compute command: core_start 1 cycle after cmd_valid.

Decomposition:
- Shared package rsa_pkg: opcode localparams (CMD_READ_A=0x0 ... CMD_RESET_MONT=0xb), state encoding, command field positions.
- Sub-module rsa_done_tracker: pending mask plus timeout counter, with inputs start/mask/core_done and outputs all_done/timeout.
- Result selection is an indexed part-select in the top module.

Test Plan:
- NUM_CORES=2, cmd 0x00000100 (READ_A, core 1), data 0xA5..A5 -> one core_ld_en=2'b10 pulse with core_ld_sel=0 and matching data; done high until done_read; status_err=0.
- Broadcast 0x80000004 (COMPUTE_MONT); core 0 done at +5 cycles, core 1 at +9 -> done asserts only after the second pulse; core_mode=0; core_start=2'b11 for 1 cycle.
- TIMEOUT_CYCLES=20, compute on core 0 with core_done never pulsed -> done after 20 WAIT cycles, status_err=1, leds[0]=1.
- cmd 0x0000010a (WRITE, core 1) with core_result[2047:1024]=0x1234 and ready delayed 3 cycles -> data_valid held for those cycles; fpga_to_arm_data=0x1234 at transfer.
- Illegal cases: cmd 0x00000500 (index 5) -> no strobes, done, err=1. cmd_valid pulsed during WAIT -> ignored, err=1. resetn low during TX -> all outputs 0 next edge, state IDLE.
